fetch_sequencer: RTL
====================

// Module: fetch_sequencer
// PURPOSE
//  Sequences instruction fetch for the non-pipelined core: owns the PC, drives the
//  instruction-memory read address and waits MEM_LAT cycles for read data.
//  Presents each instruction to decode with a valid/ready handshake.
//  Accepts branch/jump redirects and halt requests from the control unit.
//  Sits between the instruction memory (word-indexed) and the decode/execute stage.
// PARAMETERS
//  INS_ADDRESS  32  width of PC / imem address (word index)
//  INS_W        32  instruction width
//  MEM_LAT      1   imem read latency in cycles, legal range 1..15
//  RESET_PC     0   PC loaded on reset and on start from IDLE
//  PC_STEP      1   PC increment per accepted instruction (word-indexed imem)
// PORTS
//  clk             in   1            clock, rising edge
//  rst_n           in   1            asynchronous active-low reset
//  start           in   1            pulse: begin fetching (IDLE or HALTED)
//  halt_req        in   1            pulse: stop at next instruction boundary
//  redirect_valid  in   1            pulse: load redirect_pc, discard in-flight fetch
//  redirect_pc     in   INS_ADDRESS  redirect target
//  imem_addr       out  INS_ADDRESS  read address to instruction memory (= PC)
//  imem_instr      in   INS_W        read data from instruction memory
//  instr_valid     out  1            instr/instr_pc hold a fetched instruction
//  instr_ready     in   1            decode accepts instruction this cycle
//  instr           out  INS_W        fetched instruction
//  instr_pc        out  INS_ADDRESS  PC of instr
//  busy            out  1            state is FETCH or ISSUE
//  halted          out  1            state is HALTED
//  fetch_count     out  32           accepted instructions since reset, saturating
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, pc=RESET_PC, imem_addr=RESET_PC, instr=0,
//   instr_pc=0, instr_valid=0, busy=0, halted=0, fetch_count=0, wait_cnt=0, halt_pend=0.
//  Reset mid-fetch or mid-issue discards everything; no handshake completes.
//  States: IDLE, FETCH, ISSUE, HALTED. imem_addr = pc continuously.
//  IDLE: start -> pc=RESET_PC, wait_cnt=0, FETCH.
//  FETCH: wait_cnt increments each cycle; in cycle where wait_cnt==MEM_LAT-1, capture
//   instr<=imem_instr, instr_pc<=pc, go ISSUE (instr_valid=1 next cycle).
//   MEM_LAT=1 -> instr_valid rises 1 cycle after entering FETCH.
//  ISSUE: instr_valid=1; instr/instr_pc held stable until instr_ready=1.
//   Handshake (valid&ready): fetch_count+=1 (stays at 2^32-1), pc<=pc+PC_STEP
//   (mod 2^INS_ADDRESS, wraps silently), wait_cnt=0; -> HALTED if halt_pend or halt_req,
//   else FETCH. instr_valid drops the cycle after handshake.
//  Redirect (FETCH or ISSUE, highest priority after reset): pc<=redirect_pc, wait_cnt=0,
//   -> FETCH; instr_valid=0 next cycle. In ISSUE with instr_ready=1 the same cycle the
//   current instruction IS accepted (count increments) but pc takes redirect_pc.
//   Redirect in IDLE/HALTED: pc<=redirect_pc, state unchanged.
//  Halt: halt_req in FETCH aborts the read -> HALTED next cycle, pc unchanged.
//   halt_req in ISSUE without handshake sets halt_pend; ISSUE continues until handshake.
//   Redirect + halt_req together: pc<=redirect_pc, then halt rules apply (FETCH aborts).
//  HALTED: halted=1, halt_pend cleared; start -> FETCH from current pc (resume).
//  start and halt_req together in IDLE/HALTED: halt wins, state unchanged.
//  start while busy: ignored.
// TESTING
//  MEM_LAT=1, start, instr_ready=1, imem returns 0x00208033/0x40110133/.. -> instr_valid
//   every 2nd cycle, instr_pc 0,1,2,..; fetch_count=3 after 3 handshakes.
//  MEM_LAT=3, instr_ready=0 for 5 cycles in ISSUE -> instr/instr_pc stable, pc held;
//   ready=1 -> count+1, next instr_valid 4 cycles later with instr_pc=1.
//  Redirect to 0x40 during FETCH wait_cnt=1 -> imem_addr=0x40 next cycle, next
//   instr_pc=0x40; redirect in ISSUE with ready=1 -> count increments, next pc=0x40.
//  halt_req in ISSUE with ready=0 -> stays ISSUE; ready=1 -> halted=1, pc=instr_pc+1;
//   start -> resumes at that pc; halt_req in FETCH -> halted next cycle, no count.
//  pc=2^INS_ADDRESS-1 (via redirect) accepted -> pc wraps to 0.
//  rst_n low mid-ISSUE -> all outputs to reset values immediately, asynchronously.

Source files
------------

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC owner and instruction fetch sequencer for the non-pipelined core
// Drives imem with the PC, waits MEM_LAT cycles, then holds the word for decode until accepted.
module fetch_sequencer #(
    parameter int INS_ADDRESS = 32,
    parameter int INS_W       = 32,
    parameter int MEM_LAT     = 1,
    parameter logic [INS_ADDRESS-1:0] RESET_PC = '0,
    parameter logic [INS_ADDRESS-1:0] PC_STEP  = {{(INS_ADDRESS-1){1'b0}}, 1'b1}
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   halt_req,
    input  logic                   redirect_valid,
    input  logic [INS_ADDRESS-1:0] redirect_pc,
    output logic [INS_ADDRESS-1:0] imem_addr,
    input  logic [INS_W-1:0]       imem_instr,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INS_W-1:0]       instr,
    output logic [INS_ADDRESS-1:0] instr_pc,
    output logic                   busy,
    output logic                   halted,
    output logic [31:0]            fetch_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_HALTED
    } state_t;

    localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 1);

    state_t                 state;
    logic [INS_ADDRESS-1:0] pc;
    logic [3:0]             wait_cnt;
    logic                   halt_pend;
    logic                   handshake;

    assign handshake   = (state == S_ISSUE) && instr_ready;
    assign imem_addr   = pc;
    assign instr_valid = (state == S_ISSUE);
    assign busy        = (state == S_FETCH) || (state == S_ISSUE);
    assign halted      = (state == S_HALTED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            wait_cnt    <= '0;
            halt_pend   <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            fetch_count <= '0;
        end else begin
            if (handshake && (fetch_count != 32'hFFFF_FFFF))
                fetch_count <= fetch_count + 32'd1;

            case (state)
                S_IDLE, S_HALTED: begin
                    halt_pend <= 1'b0;
                    if (redirect_valid)
                        pc <= redirect_pc;
                    // halt_req beats start; a redirect beats the IDLE restart vector
                    if (start && !halt_req) begin
                        if (state == S_IDLE && !redirect_valid)
                            pc <= RESET_PC;
                        wait_cnt <= '0;
                        state    <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    if (redirect_valid) begin
                        pc       <= redirect_pc;
                        wait_cnt <= '0;
                        state    <= halt_req ? S_HALTED : S_FETCH;
                    end else if (halt_req) begin
                        wait_cnt <= '0;
                        state    <= S_HALTED;
                    end else if (wait_cnt == LAT_LAST) begin
                        instr    <= imem_instr;
                        instr_pc <= pc;
                        wait_cnt <= '0;
                        state    <= S_ISSUE;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end

                S_ISSUE: begin
                    if (redirect_valid) begin
                        // the held word is dropped unless decode takes it this same cycle
                        pc        <= redirect_pc;
                        wait_cnt  <= '0;
                        halt_pend <= 1'b0;
                        if (halt_req || (handshake && halt_pend))
                            state <= S_HALTED;
                        else
                            state <= S_FETCH;
                    end else if (handshake) begin
                        pc        <= pc + PC_STEP;
                        wait_cnt  <= '0;
                        halt_pend <= 1'b0;
                        state     <= (halt_pend || halt_req) ? S_HALTED : S_FETCH;
                    end else if (halt_req) begin
                        halt_pend <= 1'b1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
